lcd_text_page_seq: RTL and testbench

- Parametrised character-page display sequencer for the ST7735 LCD path; generalises the per-mode hard-coded "*_mode_show" blocks into one reusable engine.
- Holds a COLS x ROWS text buffer with a 2-bit colour attribute per cell, plus a 4-entry colour palette, both writable by mode logic.
- Scans the buffer and drives lcd_show_char one cell at a time using the show_char_flag / show_char_done handshake.

---
 rtl/lcd_text_page_seq.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_text_page_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_page_seq.sv
// -----------------------------------------------------------------------------
// lcd_text_page_seq
// Character-page sequencer for the ST7735 text path. It holds a COLS x ROWS
// text buffer, where each cell stores a glyph index and a 2-bit palette index,
// and a 4-entry colour palette. It scans the buffer and feeds lcd_show_char one
// cell at a time through the show_char_flag / show_char_done handshake.
//
// Optional feature macro: LCD_DIRTY_REDRAW_EN
//   When defined, each cell has a dirty bit and clean cells are skipped.
//   When undefined, every cell is redrawn on every pass.
//
// Ports
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   init_done                 LCD initialised; scanning runs only while high
//   show_char_done            one-cycle completion pulse from lcd_show_char
//   wr_en/wr_addr/wr_char/wr_attr   cell write (addr = row*COLS+col, ASCII, palette idx)
//   pal_wr_en/pal_idx/pal_bg/pal_fg palette entry write (RGB565)
//   en_size                   1 for the 16x8 font (CHAR_H==16), else 0
//   show_char_flag            one-cycle draw request for the current cell
//   ascii_num                 font index (ASCII-32)
//   start_x/start_y           cell pixel origin
//   background_color/front_color  cell colours
//   frame_done                one-cycle pulse when the last cell has completed
//   busy                      high while the buffer is cleared after reset
// -----------------------------------------------------------------------------
module lcd_text_page_seq #(
  parameter int COLS   = 20,
  parameter int ROWS   = 8,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16,
  parameter int X_OFF  = 1,
  parameter int Y_OFF  = 0,
  parameter int AW     = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          init_done,
  input  logic          show_char_done,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [6:0]    wr_char,
  input  logic [1:0]    wr_attr,
  input  logic          pal_wr_en,
  input  logic [1:0]    pal_idx,
  input  logic [15:0]   pal_bg,
  input  logic [15:0]   pal_fg,
  output logic          en_size,
  output logic          show_char_flag,
  output logic [7:0]    ascii_num,
  output logic [8:0]    start_x,
  output logic [8:0]    start_y,
  output logic [15:0]   background_color,
  output logic [15:0]   front_color,
  output logic          frame_done,
  output logic          busy
);

  localparam int NCELL = COLS * ROWS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW-1:0] LAST_CELL = AW'(NCELL - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_FETCH, S_LOAD, S_FLAG, S_WAIT} state_t;

  state_t          state_q;
  logic [AW-1:0]   cursor_q, cursor_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [8:0]      rd_q;
  logic [8:0]      ram [NCELL];
  logic [15:0]     pal_bg_q [4];
  logic [15:0]     pal_fg_q [4];
  logic            wr_ok;
  logic            last_cell;
  logic            col_last;
  logic            cell_dirty;

  // Printable ASCII maps onto the font table; anything else becomes a space.
  function automatic logic [6:0] to_glyph(input logic [6:0] c);
    return (c >= 7'd32 && c <= 7'd126) ? c - 7'd32 : 7'd0;
  endfunction

  assign en_size   = (CHAR_H == 16);
  assign wr_ok     = wr_en && (state_q != S_CLEAR) && (32'(wr_addr) < 32'(NCELL));
  assign last_cell = (cursor_q == LAST_CELL);
  assign col_last  = (col_q == LAST_COL);

  // Cursor advance shared by the clear sweep, the done handshake and dirty skips.
  always_comb begin
    cursor_d = cursor_q + AW'(1);
    col_d    = col_last ? '0 : col_q + CW'(1);
    row_d    = col_last ? row_q + RW'(1) : row_q;
    if (last_cell) begin
      cursor_d = '0;
      col_d    = '0;
      row_d    = '0;
    end
  end

  // Text buffer: one write port (clear sweep or host) and a registered read
  // taken in FETCH, so a same-cycle write to the scanned cell reads old data.
  always_ff @(posedge sys_clk) begin
    if (state_q == S_CLEAR) begin
      ram[cursor_q] <= '0;
    end else if (wr_ok) begin
      ram[wr_addr] <= {to_glyph(wr_char), wr_attr};
    end
    if (state_q == S_FETCH) begin
      rd_q <= ram[cursor_q];
    end
  end

`ifdef LCD_DIRTY_REDRAW_EN
  logic [NCELL-1:0] dirty_q;

  // The host-write set is assigned last so it wins over the FETCH clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dirty_q <= '0;
    end else begin
      if (state_q == S_CLEAR) dirty_q[cursor_q] <= 1'b1;
      if (state_q == S_FETCH && init_done) dirty_q[cursor_q] <= 1'b0;
      if (wr_ok) dirty_q[wr_addr] <= 1'b1;
    end
  end

  assign cell_dirty = dirty_q[cursor_q];
`else
  assign cell_dirty = 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q          <= S_CLEAR;
      cursor_q         <= '0;
      col_q            <= '0;
      row_q            <= '0;
      show_char_flag   <= 1'b0;
      ascii_num        <= 8'd0;
      start_x          <= 9'd0;
      start_y          <= 9'd0;
      background_color <= 16'hAF7D;
      front_color      <= 16'h0000;
      frame_done       <= 1'b0;
      busy             <= 1'b1;
      pal_bg_q[0]      <= 16'hAF7D;  pal_fg_q[0] <= 16'h0000;
      pal_bg_q[1]      <= 16'h815B;  pal_fg_q[1] <= 16'hFFFF;
      pal_bg_q[2]      <= 16'hFA20;  pal_fg_q[2] <= 16'hFFFF;
      pal_bg_q[3]      <= 16'hE73F;  pal_fg_q[3] <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      if (pal_wr_en) begin
        pal_bg_q[pal_idx] <= pal_bg;
        pal_fg_q[pal_idx] <= pal_fg;
      end
      case (state_q)
        S_CLEAR: begin
          cursor_q <= cursor_d;
          if (last_cell) begin
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          cursor_q <= '0;
          col_q    <= '0;
          row_q    <= '0;
          if (init_done) state_q <= S_FETCH;
        end
        default: begin
          // Losing init_done aborts any scan state; other outputs hold.
          if (!init_done) begin
            show_char_flag <= 1'b0;
            state_q        <= S_IDLE;
          end else begin
            case (state_q)
              S_FETCH: begin
                if (cell_dirty) begin
                  state_q <= S_LOAD;
                end else begin
                  cursor_q   <= cursor_d;
                  col_q      <= col_d;
                  row_q      <= row_d;
                  frame_done <= last_cell;
                end
              end
              S_LOAD: begin
                ascii_num        <= {1'b0, rd_q[8:2]};
                background_color <= pal_bg_q[rd_q[1:0]];
                front_color      <= pal_fg_q[rd_q[1:0]];
                start_x          <= 9'(X_OFF + CHAR_W * int'(col_q));
                start_y          <= 9'(Y_OFF + CHAR_H * int'(row_q));
                show_char_flag   <= 1'b1;
                state_q          <= S_FLAG;
              end
              S_FLAG: begin
                show_char_flag <= 1'b0;
                state_q        <= S_WAIT;
              end
              S_WAIT: begin
                if (show_char_done) begin
                  cursor_q   <= cursor_d;
                  col_q      <= col_d;
                  row_q      <= row_d;
                  frame_done <= last_cell;
                  state_q    <= S_FETCH;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_page_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_page_seq
// Self-checking bench for lcd_text_page_seq (COLS=20, ROWS=8). A behavioural
// model holds the text buffer, palette and (when LCD_DIRTY_REDRAW_EN is
// defined) dirty flags as plain arrays; the expected cell for each draw request
// and its coordinates and colours are derived from them with arithmetic. The
// bench plays lcd_show_char, answering each request after a random delay while
// issuing random cell and palette writes.
// -----------------------------------------------------------------------------
module tb_lcd_text_page_seq;

  localparam int COLS  = 20;
  localparam int ROWS  = 8;
  localparam int NCELL = COLS * ROWS;
`ifdef LCD_DIRTY_REDRAW_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        show_char_done = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [6:0]  wr_char = '0;
  logic [1:0]  wr_attr = '0;
  logic        pal_wr_en = 1'b0;
  logic [1:0]  pal_idx = '0;
  logic [15:0] pal_bg = '0;
  logic [15:0] pal_fg = '0;
  logic        en_size, show_char_flag, frame_done, busy;
  logic [7:0]  ascii_num;
  logic [8:0]  start_x, start_y;
  logic [15:0] background_color, front_color;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  int m_glyph [NCELL];
  int m_attr  [NCELL];
  bit m_dirty [NCELL];
  int m_bg [4];
  int m_fg [4];
  int m_cur;
  bit have_ref;

  always #5 sys_clk = ~sys_clk;

  lcd_text_page_seq #(.COLS(COLS), .ROWS(ROWS)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .show_char_done(show_char_done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .wr_attr(wr_attr), .pal_wr_en(pal_wr_en),
    .pal_idx(pal_idx), .pal_bg(pal_bg), .pal_fg(pal_fg), .en_size(en_size),
    .show_char_flag(show_char_flag), .ascii_num(ascii_num), .start_x(start_x),
    .start_y(start_y), .background_color(background_color),
    .front_color(front_color), .frame_done(frame_done), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Called at a negedge; returns one negedge later.
  task automatic host_write(input int addr, input int ch, input int at);
    wr_en = 1'b1; wr_addr = 8'(addr); wr_char = 7'(ch); wr_attr = 2'(at);
    @(negedge sys_clk);
    wr_en = 1'b0;
    if (addr < NCELL) begin
      m_glyph[addr] = (ch >= 32 && ch <= 126) ? ch - 32 : 0;
      m_attr[addr]  = at;
      m_dirty[addr] = 1'b1;
    end
    have_ref = 1'b0;
  endtask

  task automatic pal_write(input int idx, input int bg, input int fg);
    pal_wr_en = 1'b1; pal_idx = 2'(idx); pal_bg = 16'(bg); pal_fg = 16'(fg);
    @(negedge sys_clk);
    pal_wr_en = 1'b0;
    m_bg[idx] = bg;
    m_fg[idx] = fg;
    have_ref = 1'b0;
  endtask

  task automatic wait_flag(output int n);
    bit got;
    n = 0; got = 1'b0;
    while (n < 200 && !got) begin
      @(negedge sys_clk);
      n++;
      if (show_char_flag) got = 1'b1;
    end
    if (!got) begin
      check("flag_timeout", show_char_flag, 1);
      finish_test();
    end
  endtask

  // One scan pass. lit=1: literal checks of the directed first frame;
  // lit=2: the first draw of the pass must be cell 0.
  task automatic run_frame(input int dmin, input int dmax, input int abort_cell,
                           input int hold_cell, input bit rnd, input int lit);
    int nxt, lat, d, e_ascii, e_x, e_y, e_bg, e_fg;
    bit ended, got, first;
    ended = 1'b0; first = 1'b1;
    while (!ended) begin
      nxt = -1;
      for (int k = m_cur; k < NCELL; k++) begin
        if (nxt < 0 && (!DIRTY || m_dirty[k])) nxt = k;
      end
      if (nxt < 0) begin
        got = 1'b0;
        for (int i = 0; i < NCELL + 8 && !got; i++) begin
          @(negedge sys_clk);
          if (frame_done) got = 1'b1;
        end
        check("frame_done_wrap", got, 1);
        m_cur = 0; have_ref = 1'b1; ended = 1'b1;
      end else begin
        wait_flag(lat);
        if (have_ref) check("flag_latency", lat, 2 + (nxt - m_cur));
        e_ascii = m_glyph[nxt];
        e_x = (1 + (nxt % COLS) * 8) % 512;
        e_y = ((nxt / COLS) * 16) % 512;
        e_bg = m_bg[m_attr[nxt]];
        e_fg = m_fg[m_attr[nxt]];
        check("cell_ascii", ascii_num, e_ascii);
        check("cell_x", start_x, e_x);
        check("cell_y", start_y, e_y);
        check("cell_bg", background_color, e_bg);
        check("cell_fg", front_color, e_fg);
        if (lit == 1 && nxt == 0) begin
          check("c0_ascii", ascii_num, 0); check("c0_x", start_x, 1);
          check("c0_y", start_y, 0); check("c0_bg", background_color, 16'hAF7D);
        end
        if (lit == 1 && nxt == 21) begin
          check("c21_ascii", ascii_num, 43); check("c21_x", start_x, 9);
          check("c21_y", start_y, 16); check("c21_bg", background_color, 16'h815B);
          check("c21_fg", front_color, 16'hFFFF);
        end
        if (lit == 1 && nxt == 50) begin
          check("c50_bg", background_color, 16'h001F);
          check("c50_fg", front_color, 16'hF800);
        end
        if (lit == 1 && (nxt == 3 || nxt == 11)) check("blank_ascii", ascii_num, 0);
        if (lit == 2 && first) check("restart_cell0_x", start_x, 1);
        first = 1'b0;
        m_dirty[nxt] = 1'b0;
        m_cur = nxt;
        if (nxt == abort_cell) begin
          @(negedge sys_clk);
          init_done = 1'b0;
          for (int i = 0; i < 12; i++) begin
            show_char_done = (i % 3 == 1);
            @(negedge sys_clk);
            check("abort_flag", show_char_flag, 0);
            check("abort_hold_ascii", ascii_num, e_ascii);
            check("abort_frame_done", frame_done, 0);
          end
          show_char_done = 1'b0;
          init_done = 1'b1;
          m_cur = 0; have_ref = 1'b0; ended = 1'b1;
        end else begin
          if (rnd && $urandom_range(0, 2) == 0)
            host_write($urandom_range(0, 199), $urandom_range(0, 127), $urandom_range(0, 3));
          if (rnd && $urandom_range(0, 15) == 0)
            pal_write($urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 65535));
          d = (nxt == hold_cell) ? 50 : $urandom_range(dmin, dmax);
          for (int i = 0; i < d; i++) begin
            @(negedge sys_clk);
            check("hold_flag", show_char_flag, 0);
            check("hold_ascii", ascii_num, e_ascii);
            check("hold_x", start_x, e_x);
            check("hold_bg", background_color, e_bg);
            check("hold_fg", front_color, e_fg);
          end
          show_char_done = 1'b1;
          @(negedge sys_clk);
          show_char_done = 1'b0;
          check("frame_done", frame_done, (nxt == NCELL - 1));
          if (nxt == NCELL - 1) begin
            m_cur = 0; ended = 1'b1;
          end else begin
            m_cur = nxt + 1;
          end
          have_ref = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_test();
  end

  initial begin
    int bcnt;
`ifdef LCD_DIRTY_REDRAW_EN
    int elapsed, nflag;
    bit fdone;
`endif
    for (int k = 0; k < NCELL; k++) begin
      m_glyph[k] = 0; m_attr[k] = 0; m_dirty[k] = 1'b1;
    end
    m_bg[0] = 16'hAF7D; m_fg[0] = 16'h0000;
    m_bg[1] = 16'h815B; m_fg[1] = 16'hFFFF;
    m_bg[2] = 16'hFA20; m_fg[2] = 16'hFFFF;
    m_bg[3] = 16'hE73F; m_fg[3] = 16'h0000;
    m_cur = 0; have_ref = 1'b0;

    @(negedge sys_clk);
    check("rst_busy", busy, 1);
    check("rst_flag", show_char_flag, 0);
    check("rst_ascii", ascii_num, 0);
    check("rst_x", start_x, 0);
    check("rst_y", start_y, 0);
    check("rst_bg", background_color, 16'hAF7D);
    check("rst_fg", front_color, 16'h0000);
    check("rst_frame_done", frame_done, 0);
    check("en_size", en_size, 1);

    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (!busy) break;
      bcnt++;
      // A write during the clear sweep must be dropped (model left untouched).
      if (bcnt == 20) begin
        wr_en = 1'b1; wr_addr = 8'd3; wr_char = 7'd90; wr_attr = 2'd1;
      end
      if (bcnt == 21) wr_en = 1'b0;
    end
    check("busy_len", bcnt, 160);
    check("busy_low", busy, 0);

    host_write(21, 75, 1);
    host_write(11, 65, 0);
    host_write(11, 10, 3);
    host_write(200, 81, 3);
    pal_write(2, 16'h001F, 16'hF800);
    host_write(50, 65, 2);
    host_write(37, 35, 1);
    init_done = 1'b1;

    run_frame(3, 3, -1, 50, 1'b0, 1);
    run_frame(1, 4, -1, -1, 1'b1, 0);
    run_frame(1, 4, -1, -1, 1'b1, 0);
    host_write(37, $urandom_range(32, 126), $urandom_range(0, 3));
    run_frame(1, 3, 37, -1, 1'b1, 0);
`ifdef LCD_DIRTY_REDRAW_EN
    run_frame(1, 4, -1, -1, 1'b1, 0);
    run_frame(1, 2, -1, -1, 1'b0, 0);
    host_write(5, 72, 1);
    elapsed = 1; nflag = 0; fdone = 1'b0;
    while (elapsed < 170 && !fdone) begin
      @(negedge sys_clk);
      elapsed++;
      if (frame_done) fdone = 1'b1;
      if (show_char_flag) begin
        nflag++;
        check("dirty_c5_x", start_x, 41);
        check("dirty_c5_ascii", ascii_num, 40);
        @(negedge sys_clk);
        elapsed++;
        show_char_done = 1'b1;
        @(negedge sys_clk);
        elapsed++;
        show_char_done = 1'b0;
        if (frame_done) fdone = 1'b1;
      end
    end
    check("dirty_one_flag", nflag, 1);
    check("dirty_frame_done", fdone, 1);
    check("dirty_frame_time", (elapsed <= 164), 1);
`else
    run_frame(1, 4, -1, -1, 1'b1, 2);
`endif
    finish_test();
  end

endmodule
